// File: rtl/mem_port_arbiter.sv
// Two-master (fetch/data) arbiter onto a single memory port with round-robin
// conflict resolution, one outstanding access, and a busy-cycle timeout.
module mem_port_arbiter #(
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [DWIDTH-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DWIDTH-1:0] f_rdata,
    input  logic              d_req,
    input  logic [DWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    input  logic              d_wren,
    input  logic [1:0]        d_size,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DWIDTH-1:0] d_rdata,
    output logic              m_req,
    output logic [DWIDTH-1:0] m_addr,
    output logic [DWIDTH-1:0] m_wdata,
    output logic              m_wren,
    output logic [1:0]        m_size,
    input  logic              m_ack,
    input  logic [DWIDTH-1:0] m_rdata,
    output logic              err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_F = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    state_t            state_r, state_s;
    owner_t            last_owner_r;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic              f_win_s, d_win_s, done_s, tmo_s;
    logic [DWIDTH-1:0] addr_r, wdata_r;
    logic              wren_r;
    logic [1:0]        size_r;
    logic              f_rvalid_r, d_rvalid_r, err_r;
    logic [DWIDTH-1:0] f_rdata_r, d_rdata_r;

    // Next-state, arbitration and busy-counter logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        f_win_s = 1'b0;
        d_win_s = 1'b0;
        done_s  = 1'b0;
        tmo_s   = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = {CW{1'b0}};
                // Grant is a same-cycle handshake, so it must be masked while reset is held
                if (reset) begin
                    state_s = IDLE;
                end else if (f_req && d_req) begin
                    if (last_owner_r == OWNER_F) begin
                        d_win_s = 1'b1;
                        state_s = BUSY_D;
                    end else begin
                        f_win_s = 1'b1;
                        state_s = BUSY_F;
                    end
                end else if (f_req) begin
                    f_win_s = 1'b1;
                    state_s = BUSY_F;
                end else if (d_req) begin
                    d_win_s = 1'b1;
                    state_s = BUSY_D;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_F, BUSY_D: begin
                if (m_ack) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                    tmo_s   = 1'b1;
                    state_s = IDLE;
                end else begin
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, busy counter and round-robin owner registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
            last_owner_r <= OWNER_F;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (f_win_s) begin
                last_owner_r <= OWNER_F;
            end else if (d_win_s) begin
                last_owner_r <= OWNER_D;
            end else begin
                last_owner_r <= last_owner_r;
            end
        end
    end

    // Request capture at grant; fetch is always a word read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r  <= {DWIDTH{1'b0}};
            wdata_r <= {DWIDTH{1'b0}};
            wren_r  <= 1'b0;
            size_r  <= 2'd0;
        end else if (f_win_s) begin
            addr_r  <= f_addr;
            wdata_r <= {DWIDTH{1'b0}};
            wren_r  <= 1'b0;
            size_r  <= 2'd2;
        end else if (d_win_s) begin
            addr_r  <= d_addr;
            wdata_r <= d_wdata;
            wren_r  <= d_wren;
            size_r  <= d_size;
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            wren_r  <= wren_r;
            size_r  <= size_r;
        end
    end

    // Completion pulses and response data; a timeout completes with zero data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            err_r      <= 1'b0;
            f_rdata_r  <= {DWIDTH{1'b0}};
            d_rdata_r  <= {DWIDTH{1'b0}};
        end else begin
            f_rvalid_r <= (done_s || tmo_s) && (state_r == BUSY_F);
            d_rvalid_r <= (done_s || tmo_s) && (state_r == BUSY_D);
            err_r      <= tmo_s;
            if (state_r == BUSY_F && done_s) begin
                f_rdata_r <= m_rdata;
            end else if (state_r == BUSY_F && tmo_s) begin
                f_rdata_r <= {DWIDTH{1'b0}};
            end else begin
                f_rdata_r <= f_rdata_r;
            end
            if (state_r == BUSY_D && done_s) begin
                d_rdata_r <= wren_r ? {DWIDTH{1'b0}} : m_rdata;
            end else if (state_r == BUSY_D && tmo_s) begin
                d_rdata_r <= {DWIDTH{1'b0}};
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    assign f_gnt    = f_win_s;
    assign d_gnt    = d_win_s;
    assign m_req    = (state_r != IDLE);
    assign m_addr   = addr_r;
    assign m_wdata  = wdata_r;
    assign m_wren   = wren_r;
    assign m_size   = size_r;
    assign f_rvalid = f_rvalid_r;
    assign d_rvalid = d_rvalid_r;
    assign f_rdata  = f_rdata_r;
    assign d_rdata  = d_rdata_r;
    assign err      = err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          f_req = 1'b0, d_req = 1'b0, d_wren = 1'b0, m_ack = 1'b0;
    logic [DW-1:0] f_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
    logic [1:0]    d_size = 2'd0;
    logic          f_gnt, f_rvalid, d_gnt, d_rvalid, m_req, m_wren, err;
    logic [DW-1:0] f_rdata, d_rdata, m_addr, m_wdata;
    logic [1:0]    m_size;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(.DWIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wren(d_wren), .d_size(d_size),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_wren(m_wren), .m_size(m_size),
        .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        f_req = 1'b0; d_req = 1'b0; d_wren = 1'b0; m_ack = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; d_size = 2'd0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        f_req = 1'b1; d_req = 1'b1; m_ack = 1'b1; m_rdata = 32'h1234_5678;
        reset = 1'b1;
        #2;
        n_checks++; if ({f_gnt, d_gnt, m_req, m_wren, f_rvalid, d_rvalid, err} !== 7'd0) $display("FAIL reset_ctrl: got %b want 0000000", {f_gnt, d_gnt, m_req, m_wren, f_rvalid, d_rvalid, err}); else n_pass++;
        n_checks++; if ({m_addr, m_wdata, f_rdata, d_rdata, m_size} !== 130'd0) $display("FAIL reset_data: got %h want 0", {m_addr, m_wdata, f_rdata, d_rdata, m_size}); else n_pass++;
        step();
        n_checks++; if ({f_gnt, d_gnt, m_req} !== 3'd0) $display("FAIL reset_held: got %b want 000", {f_gnt, d_gnt, m_req}); else n_pass++;
        idle_inputs();
        #1 reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        do_reset();
        f_req = 1'b1; f_addr = 32'h0100_0000;
        @(negedge clk);
        n_checks++; if ({f_gnt, d_gnt, m_req} !== 3'b100) $display("FAIL fetch_gnt: got %b want 100", {f_gnt, d_gnt, m_req}); else n_pass++;
        step();
        f_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hfd01_0113;
        @(negedge clk);
        n_checks++; if ({m_req, m_addr, m_wren, m_size} !== {1'b1, 32'h0100_0000, 1'b0, 2'd2}) $display("FAIL fetch_mreq: got %b %h %b %d want 1 01000000 0 2", m_req, m_addr, m_wren, m_size); else n_pass++;
        n_checks++; if (f_rvalid !== 1'b0) $display("FAIL fetch_early_rvalid: got %b want 0", f_rvalid); else n_pass++;
        step();
        m_ack = 1'b0; m_rdata = '0;
        @(negedge clk);
        n_checks++; if ({f_rvalid, d_rvalid, err, m_req} !== 4'b1000) $display("FAIL fetch_rvalid: got %b want 1000", {f_rvalid, d_rvalid, err, m_req}); else n_pass++;
        n_checks++; if (f_rdata !== 32'hfd01_0113) $display("FAIL fetch_rdata: got %h want fd010113", f_rdata); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (f_rvalid !== 1'b0) $display("FAIL fetch_pulse: got %b want 0", f_rvalid); else n_pass++;
    endtask

    task automatic test_conflict();
        do_reset();
        f_req = 1'b1; f_addr = 32'h0000_1000;
        d_req = 1'b1; d_addr = 32'h0000_2000; d_wren = 1'b0; d_size = 2'd2;
        @(negedge clk);
        n_checks++; if ({f_gnt, d_gnt} !== 2'b01) $display("FAIL conflict_first: got %b want 01", {f_gnt, d_gnt}); else n_pass++;
        step();
        m_ack = 1'b1; m_rdata = 32'h1111_2222;
        @(negedge clk);
        n_checks++; if ({f_gnt, d_gnt, m_addr} !== {2'b00, 32'h0000_2000}) $display("FAIL conflict_busy_d: got %b %h want 00 00002000", {f_gnt, d_gnt}, m_addr); else n_pass++;
        step();
        m_ack = 1'b0;
        @(negedge clk);
        n_checks++; if ({d_rvalid, f_gnt, d_gnt} !== 3'b110) $display("FAIL conflict_second: got %b want 110", {d_rvalid, f_gnt, d_gnt}); else n_pass++;
        n_checks++; if (d_rdata !== 32'h1111_2222) $display("FAIL conflict_drdata: got %h want 11112222", d_rdata); else n_pass++;
        step();
        m_ack = 1'b1; m_rdata = 32'h3333_4444;
        @(negedge clk);
        n_checks++; if (m_addr !== 32'h0000_1000) $display("FAIL conflict_busy_f: got %h want 00001000", m_addr); else n_pass++;
        step();
        m_ack = 1'b0;
        @(negedge clk);
        n_checks++; if ({f_rvalid, f_gnt, d_gnt} !== 3'b101) $display("FAIL conflict_third: got %b want 101", {f_rvalid, f_gnt, d_gnt}); else n_pass++;
        n_checks++; if (f_rdata !== 32'h3333_4444) $display("FAIL conflict_frdata: got %h want 33334444", f_rdata); else n_pass++;
    endtask

    task automatic test_store();
        do_reset();
        d_req = 1'b1; d_wren = 1'b1; d_size = 2'd0; d_addr = 32'h0100_0100; d_wdata = 32'h0000_00AB;
        @(negedge clk);
        n_checks++; if (d_gnt !== 1'b1) $display("FAIL store_gnt: got %b want 1", d_gnt); else n_pass++;
        step();
        d_req = 1'b0; d_wren = 1'b0; d_size = 2'd2; d_addr = 32'hdead_beef; d_wdata = 32'h5555_5555;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin m_ack = 1'b1; m_rdata = 32'hffff_ffff; end
            @(negedge clk);
            n_checks++; if ({m_req, m_wren, m_size, m_addr, m_wdata} !== {1'b1, 1'b1, 2'd0, 32'h0100_0100, 32'h0000_00AB}) $display("FAIL store_fields: cyc %0d got %b %b %d %h %h", i, m_req, m_wren, m_size, m_addr, m_wdata); else n_pass++;
            step();
        end
        m_ack = 1'b0;
        @(negedge clk);
        n_checks++; if ({d_rvalid, f_rvalid, err, d_rdata} !== {3'b100, 32'd0}) $display("FAIL store_done: got %b %h want 100 0", {d_rvalid, f_rvalid, err}, d_rdata); else n_pass++;
    endtask

    task automatic test_timeout();
        int busy;
        do_reset();
        f_req = 1'b1; f_addr = 32'h0100_0040;
        @(negedge clk);
        n_checks++; if (f_gnt !== 1'b1) $display("FAIL tmo_gnt: got %b want 1", f_gnt); else n_pass++;
        step();
        f_req = 1'b0;
        busy = 0;
        @(negedge clk);
        while (m_req === 1'b1 && busy < 40) begin
            busy++;
            step();
            @(negedge clk);
        end
        n_checks++; if (busy != TMO) $display("FAIL tmo_len: got %0d cycles want %0d", busy, TMO); else n_pass++;
        n_checks++; if ({err, f_rvalid, d_rvalid, f_rdata} !== {3'b110, 32'd0}) $display("FAIL tmo_err: got %b %h want 110 0", {err, f_rvalid, d_rvalid}, f_rdata); else n_pass++;
        step();
        f_req = 1'b1; f_addr = 32'h0100_0080;
        @(negedge clk);
        n_checks++; if ({err, f_rvalid, f_gnt} !== 3'b001) $display("FAIL tmo_after: got %b want 001", {err, f_rvalid, f_gnt}); else n_pass++;
        step();
        f_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hcafe_f00d;
        step();
        m_ack = 1'b0;
        @(negedge clk);
        n_checks++; if ({f_rvalid, err, f_rdata} !== {2'b10, 32'hcafe_f00d}) $display("FAIL tmo_recover: got %b %h want 10 cafef00d", {f_rvalid, err}, f_rdata); else n_pass++;
        step();
        f_req = 1'b1;
        @(negedge clk);
        step();
        f_req = 1'b0;
        repeat (15) @(posedge clk);
        #1 m_ack = 1'b1; m_rdata = 32'h0bad_f00d;
        step();
        m_ack = 1'b0;
        @(negedge clk);
        n_checks++; if ({f_rvalid, err, f_rdata} !== {2'b10, 32'h0bad_f00d}) $display("FAIL tmo_coincident: got %b %h want 10 0badf00d", {f_rvalid, err}, f_rdata); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        f_req = 1'b1; f_addr = 32'h0100_0200;
        @(negedge clk);
        step();
        f_req = 1'b0;
        step();
        step();
        @(negedge clk);
        n_checks++; if (m_req !== 1'b1) $display("FAIL rstmid_busy: got %b want 1", m_req); else n_pass++;
        #1 reset = 1'b1;
        m_ack = 1'b1;
        #1;
        n_checks++; if ({m_req, f_gnt, f_rvalid, err, m_addr} !== 36'd0) $display("FAIL rstmid_async: got %b %h want 0", {m_req, f_gnt, f_rvalid, err}, m_addr); else n_pass++;
        step();
        m_ack = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if ({f_rvalid, d_rvalid, err, m_req} !== 4'd0) $display("FAIL rstmid_quiet: cyc %0d got %b want 0000", i, {f_rvalid, d_rvalid, err, m_req}); else n_pass++;
            step();
        end
        f_req = 1'b1;
        @(negedge clk);
        n_checks++; if (f_gnt !== 1'b1) $display("FAIL rstmid_regrant: got %b want 1", f_gnt); else n_pass++;
        step();
        f_req = 1'b0;
    endtask

    task automatic test_stray();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            m_ack = 1'($urandom_range(0, 1)); m_rdata = $urandom;
            @(negedge clk);
            n_checks++; if ({f_gnt, d_gnt, f_rvalid, d_rvalid, err, m_req} !== 6'd0) $display("FAIL stray_ack: cyc %0d got %b want 000000", i, {f_gnt, d_gnt, f_rvalid, d_rvalid, err, m_req}); else n_pass++;
            step();
        end
        m_ack = 1'b0;
        d_req = 1'b1; d_addr = 32'h0000_0300;
        @(negedge clk);
        step();
        d_req = 1'b0; f_req = 1'b1;
        @(negedge clk);
        n_checks++; if (f_gnt !== 1'b0) $display("FAIL drop_busy_gnt: got %b want 0", f_gnt); else n_pass++;
        step();
        f_req = 1'b0;
        step();
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if ({f_gnt, f_rvalid, err, m_req} !== 4'd0) $display("FAIL drop_no_effect: cyc %0d got %b want 0000", i, {f_gnt, f_rvalid, err, m_req}); else n_pass++;
            step();
        end
    endtask

    task automatic test_random();
        int owner, waited;
        bit last_d, silent, eg_f, eg_d, e_fv, e_dv, e_err, c_wren;
        logic [DW-1:0] c_addr, c_wdata, e_frd, e_drd;
        logic [1:0] c_size;
        owner = 0; waited = 0; last_d = 1'b0; silent = 1'b0;
        eg_f = 1'b0; eg_d = 1'b0; e_fv = 1'b0; e_dv = 1'b0; e_err = 1'b0;
        c_addr = '0; c_wdata = '0; c_wren = 1'b0; c_size = 2'd0; e_frd = '0; e_drd = '0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!f_req) begin
                if ($urandom_range(0, 2) == 0) begin f_req = 1'b1; f_addr = $urandom; end
            end else if (eg_f) begin
                f_req = 1'($urandom_range(0, 1)); f_addr = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                f_req = 1'b0;
            end
            if (!d_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom;
                    d_wren = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
                end
            end else if (eg_d) begin
                d_req = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
                d_wren = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
            end else if ($urandom_range(0, 15) == 0) begin
                d_req = 1'b0;
            end
            if (owner != 0) m_ack = silent ? 1'b0 : ($urandom_range(0, 9) < 4);
            else m_ack = ($urandom_range(0, 4) == 0);
            m_rdata = $urandom;
            @(negedge clk);
            eg_f = (owner == 0) && f_req && (!d_req || last_d);
            eg_d = (owner == 0) && d_req && (!f_req || !last_d);
            n_checks++; if ({f_gnt, d_gnt} !== {eg_f, eg_d}) $display("FAIL rnd_gnt: cyc %0d got %b want %b", cyc, {f_gnt, d_gnt}, {eg_f, eg_d}); else n_pass++;
            n_checks++; if ({m_req, f_rvalid, d_rvalid, err} !== {owner != 0, e_fv, e_dv, e_err}) $display("FAIL rnd_status: cyc %0d got %b want %b", cyc, {m_req, f_rvalid, d_rvalid, err}, {owner != 0, e_fv, e_dv, e_err}); else n_pass++;
            if (owner != 0) begin
                n_checks++; if ({m_addr, m_wren, m_size} !== {c_addr, c_wren, c_size}) $display("FAIL rnd_mfields: cyc %0d got %h %b %d want %h %b %d", cyc, m_addr, m_wren, m_size, c_addr, c_wren, c_size); else n_pass++;
            end
            if (owner == 2) begin
                n_checks++; if (m_wdata !== c_wdata) $display("FAIL rnd_wdata: cyc %0d got %h want %h", cyc, m_wdata, c_wdata); else n_pass++;
            end
            if (e_fv) begin
                n_checks++; if (f_rdata !== e_frd) $display("FAIL rnd_frdata: cyc %0d got %h want %h", cyc, f_rdata, e_frd); else n_pass++;
            end
            if (e_dv) begin
                n_checks++; if (d_rdata !== e_drd) $display("FAIL rnd_drdata: cyc %0d got %h want %h", cyc, d_rdata, e_drd); else n_pass++;
            end
            e_fv = 1'b0; e_dv = 1'b0; e_err = 1'b0;
            if (owner == 0) begin
                if (eg_f || eg_d) begin
                    owner  = eg_f ? 1 : 2;
                    c_addr = eg_f ? f_addr : d_addr;
                    c_wdata = d_wdata;
                    c_wren = eg_f ? 1'b0 : d_wren;
                    c_size = eg_f ? 2'd2 : d_size;
                    last_d = eg_d;
                    waited = 0;
                    silent = ($urandom_range(0, 15) == 0);
                end
            end else if (m_ack) begin
                if (owner == 1) begin e_fv = 1'b1; e_frd = m_rdata; end
                else begin e_dv = 1'b1; e_drd = c_wren ? '0 : m_rdata; end
                owner = 0;
            end else if (waited == TMO - 1) begin
                e_err = 1'b1;
                if (owner == 1) begin e_fv = 1'b1; e_frd = '0; end
                else begin e_dv = 1'b1; e_drd = '0; end
                owner = 0;
            end else begin
                waited++;
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_conflict();
        test_store();
        test_timeout();
        test_reset_mid();
        test_stray();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
